// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: vehicle-actuated two-road intersection controller; road A rests in green.
// Define TRAFFIC_PED_EN to compile in the pedestrian walk phase after RED_BA.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned GREEN_SEC  = 5,
  parameter int unsigned YELLOW_SEC = 1,
  parameter int unsigned ALLRED_SEC = 1,
  parameter int unsigned WALK_SEC   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_B,
  input  logic       ped_req,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       walk,
  output logic       req_B_pend
);

  typedef enum logic [2:0] {
    StAGrn  = 3'd0,
    StAYel  = 3'd1,
    StRedAb = 3'd2,
    StBGrn  = 3'd3,
    StBYel  = 3'd4,
    StRedBa = 3'd5
`ifdef TRAFFIC_PED_EN
    ,
    StPed   = 3'd6
`endif
  } state_e;

  localparam logic [2:0] LampGrn = 3'b001;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampRed = 3'b100;

  localparam logic [CNT_W-1:0] TickMax  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GreenM1  = CNT_W'(GREEN_SEC - 1);
  localparam logic [CNT_W-1:0] YellowM1 = CNT_W'(YELLOW_SEC - 1);
  localparam logic [CNT_W-1:0] AllRedM1 = CNT_W'(ALLRED_SEC - 1);
  localparam logic [CNT_W-1:0] TmrMax   = {CNT_W{1'b1}};

  state_e           state_q, state_n;
  logic [CNT_W-1:0] pre_q, tmr_q;
  logic             req_q;
  logic             sec_tick;

`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W-1:0] WalkM1 = CNT_W'(WALK_SEC - 1);
  logic ped_q;
`else
  logic unused_ped;
  assign unused_ped = ped_req ^ (WALK_SEC == 0);
`endif

  assign sec_tick   = (pre_q == TickMax);
  assign req_B_pend = req_q;

  always_comb begin
    state_n = state_q;
    case (state_q)
      StAGrn:  if (sec_tick && tmr_q >= GreenM1 && (req_q || car_B)) state_n = StAYel;
      StAYel:  if (sec_tick && tmr_q == YellowM1) state_n = StRedAb;
      StRedAb: if (sec_tick && tmr_q == AllRedM1) state_n = StBGrn;
      StBGrn:  if (sec_tick && tmr_q == GreenM1) state_n = StBYel;
      StBYel:  if (sec_tick && tmr_q == YellowM1) state_n = StRedBa;
`ifdef TRAFFIC_PED_EN
      StRedBa: if (sec_tick && tmr_q == AllRedM1) state_n = ped_q ? StPed : StAGrn;
      StPed:   if (sec_tick && tmr_q == WalkM1) state_n = StAGrn;
`else
      StRedBa: if (sec_tick && tmr_q == AllRedM1) state_n = StAGrn;
`endif
      default: state_n = StAGrn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAGrn;
      pre_q   <= '0;
      tmr_q   <= '0;
      req_q   <= 1'b0;
`ifdef TRAFFIC_PED_EN
      ped_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      // Any transition, including recovery from an illegal encoding, restarts the timers.
      if (state_n != state_q) begin
        pre_q <= '0;
        tmr_q <= '0;
      end else if (sec_tick) begin
        pre_q <= '0;
        if (tmr_q != TmrMax) tmr_q <= tmr_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      // Clear on B_GRN entry wins over a simultaneous sensor set.
      if (state_n == StBGrn && state_q != StBGrn) req_q <= 1'b0;
      else if (car_B && state_q != StBGrn)         req_q <= 1'b1;
`ifdef TRAFFIC_PED_EN
      if (state_n == StPed && state_q != StPed) ped_q <= 1'b0;
      else if (ped_req && state_q != StPed)      ped_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    light_A = LampGrn;
    light_B = LampRed;
    walk    = 1'b0;
    case (state_q)
      StAGrn:  begin light_A = LampGrn; light_B = LampRed; end
      StAYel:  begin light_A = LampYel; light_B = LampRed; end
      StRedAb: begin light_A = LampRed; light_B = LampRed; end
      StBGrn:  begin light_A = LampRed; light_B = LampGrn; end
      StBYel:  begin light_A = LampRed; light_B = LampYel; end
      StRedBa: begin light_A = LampRed; light_B = LampRed; end
`ifdef TRAFFIC_PED_EN
      StPed:   begin light_A = LampRed; light_B = LampRed; walk = 1'b1; end
`endif
      default: begin light_A = LampGrn; light_B = LampRed; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: default instance plus a TICK_DIV=4 instance.
module tb_traffic_light_ctrl;

  localparam logic [6:0] AG = 7'b001_100_0;
  localparam logic [6:0] AY = 7'b010_100_0;
  localparam logic [6:0] RR = 7'b100_100_0;
  localparam logic [6:0] BG = 7'b100_001_0;
  localparam logic [6:0] BY = 7'b100_010_0;
`ifdef TRAFFIC_PED_EN
  localparam logic [6:0] PD = 7'b100_100_1;
`endif

  typedef struct {
    bit          sel;
    string       nm;
    logic [7:0]  exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst1 = 1'b1, car1 = 1'b0, ped1 = 1'b0;
  logic rst4 = 1'b1, car4 = 1'b0, ped4 = 1'b0;
  logic [2:0] la1, lb1, la4, lb4;
  logic walk1, walk4, req1, req4;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mon_got;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl dut1 (
    .clk        (clk),
    .rst        (rst1),
    .car_B      (car1),
    .ped_req    (ped1),
    .light_A    (la1),
    .light_B    (lb1),
    .walk       (walk1),
    .req_B_pend (req1)
  );

  traffic_light_ctrl #(.TICK_DIV(4)) dut4 (
    .clk        (clk),
    .rst        (rst4),
    .car_B      (car4),
    .ped_req    (ped4),
    .light_A    (la4),
    .light_B    (lb4),
    .walk       (walk4),
    .req_B_pend (req4)
  );

  // Expected outputs for the state after this posedge; inputs set after return hit the next edge.
  task automatic tick(input bit sel, input string nm, input logic [6:0] lamps, input logic rq);
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = sel;
    e.nm  = nm;
    e.exp = {lamps, rq};
    exp_q.push_back(e);
  endtask

  task automatic ticks(input bit sel, input string nm, input logic [6:0] lamps, input logic rq,
                       input int n);
    for (int i = 0; i < n; i++) tick(sel, nm, lamps, rq);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = mon_e.sel ? {la4, lb4, walk4, req4} : {la1, lb1, walk1, req1};
      n_total++;
      if (mon_got === mon_e.exp) n_pass++;
      else $display("FAIL %s (dut%0d) at %0t: got A/B/walk/req=%b expected %b",
                    mon_e.nm, mon_e.sel ? 4 : 1, $time, mon_got, mon_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Idle: no vehicle, A holds green.
    tick(0, "reset", AG, 1'b0);
    n_total++;
    if ({la1, lb1, walk1, req1} === 8'b001_100_0_0) n_pass++;
    else $display("FAIL direct reset outputs: got %b", {la1, lb1, walk1, req1});
    rst1 = 1'b0;
    ticks(0, "idle_hold", AG, 1'b0, 50);

    // car_B held from reset: 5/1/1/5/1/1 pattern.
    rst1 = 1'b1; car1 = 1'b1;
    tick(0, "rst_car", AG, 1'b0);
    rst1 = 1'b0;
    ticks(0, "car_ag", AG, 1'b1, 4);
    for (int c = 0; c < 2; c++) begin
      tick(0, "car_ay", AY, 1'b1);
      tick(0, "car_rab", RR, 1'b1);
      ticks(0, "car_bg", BG, 1'b0, 5);
      tick(0, "car_by", BY, 1'b0);
      if (c == 0) begin
        tick(0, "car_rba", RR, 1'b1);
        ticks(0, "car_ag2", AG, 1'b1, 5);
      end
    end

    // Reset during B_YEL with car_B still high: straight to A green, request cleared.
    rst1 = 1'b1;
    tick(0, "rst_byel", AG, 1'b0);
    n_total++;
    if (req1 === 1'b0 && la1 === 3'b001) n_pass++;
    else $display("FAIL direct rst_byel: req=%b A=%b", req1, la1);
    rst1 = 1'b0;
    ticks(0, "post_rst_ag", AG, 1'b1, 4);
    tick(0, "post_rst_ay", AY, 1'b1);

    // car_B pulse during B_GRN only is not latched.
    rst1 = 1'b1; car1 = 1'b0;
    tick(0, "rst6", AG, 1'b0);
    rst1 = 1'b0; car1 = 1'b1;
    tick(0, "pulse_ag", AG, 1'b1);
    car1 = 1'b0;
    ticks(0, "pulse_ag_hold", AG, 1'b1, 3);
    tick(0, "pulse_ay", AY, 1'b1);
    tick(0, "pulse_rab", RR, 1'b1);
    tick(0, "pulse_bg1", BG, 1'b0);
    car1 = 1'b1;
    tick(0, "bg_pulse", BG, 1'b0);
    car1 = 1'b0;
    ticks(0, "bg_rest", BG, 1'b0, 3);
    tick(0, "bg_by", BY, 1'b0);
    tick(0, "bg_rba", RR, 1'b0);
    ticks(0, "no_req_hold", AG, 1'b0, 20);

`ifdef TRAFFIC_PED_EN
    // Pedestrian request during B_GRN inserts PED once.
    rst1 = 1'b1; car1 = 1'b1;
    tick(0, "rst_ped", AG, 1'b0);
    rst1 = 1'b0;
    ticks(0, "ped_ag", AG, 1'b1, 4);
    tick(0, "ped_ay", AY, 1'b1);
    tick(0, "ped_rab", RR, 1'b1);
    tick(0, "ped_bg1", BG, 1'b0);
    ped1 = 1'b1;
    tick(0, "ped_bg2", BG, 1'b0);
    ped1 = 1'b0;
    ticks(0, "ped_bg", BG, 1'b0, 3);
    tick(0, "ped_by", BY, 1'b0);
    tick(0, "ped_rba", RR, 1'b1);
    ticks(0, "ped_walk", PD, 1'b1, 4);
    ticks(0, "ped_ag2", AG, 1'b1, 5);
    tick(0, "ped_ay2", AY, 1'b1);
    tick(0, "ped_rab2", RR, 1'b1);
    ticks(0, "ped_bg3", BG, 1'b0, 5);
    tick(0, "ped_by2", BY, 1'b0);
    tick(0, "ped_rba2", RR, 1'b1);
    ticks(0, "ped_skip_ag", AG, 1'b1, 2);
    car1 = 1'b0;
`endif

    // TICK_DIV=4: pulse sampled at edge 30 is served at the edge-32 second boundary.
    tick(1, "rst4", AG, 1'b0);
    rst4 = 1'b0;
    ticks(1, "t4_idle", AG, 1'b0, 29);
    car4 = 1'b1;
    tick(1, "t4_pulse", AG, 1'b1);
    n_total++;
    if (req4 === 1'b1) n_pass++;
    else $display("FAIL direct t4_pulse: req=%b", req4);
    car4 = 1'b0;
    tick(1, "t4_wait", AG, 1'b1);
    ticks(1, "t4_ay", AY, 1'b1, 4);
    ticks(1, "t4_rab", RR, 1'b1, 4);
    ticks(1, "t4_bg", BG, 1'b0, 20);
    n_total++;
    if (lb4 === 3'b001) n_pass++;
    else $display("FAIL direct t4_bg end: B=%b", lb4);
    ticks(1, "t4_by", BY, 1'b0, 4);
    ticks(1, "t4_rba", RR, 1'b0, 4);
    ticks(1, "t4_ag_hold", AG, 1'b0, 8);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    if (n_pass != n_total) begin
      $display("FAIL: %0d check(s) failed", n_total - n_pass);
      $fatal(1);
    end
    $finish;
  end

endmodule
